// File: rtl/if_id_fetch_ctrl_pkg.sv
// Shared LC-3b types for the fetch stage: machine word, fetch FSM states,
// PC step, and the {pc, ir} entry carried through the skid buffer.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HOLD
  } fetch_state_t;

  localparam lc3b_word PC_INC = 16'd2;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word ir;
  } fetch_entry_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic lc3b_word sat_inc(input lc3b_word value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/if_id_fetch_ctrl_if.sv
// Instruction-memory read handshake between the fetch controller (master)
// and the instruction memory (slave).
interface if_id_fetch_ctrl_if;
  import lc3b_types::*;

  logic     i_mem_read;
  lc3b_word i_mem_address;
  logic     i_mem_resp;
  lc3b_word i_mem_rdata;

  modport master (
    output i_mem_read,
    output i_mem_address,
    input  i_mem_resp,
    input  i_mem_rdata
  );

  modport slave (
    input  i_mem_read,
    input  i_mem_address,
    output i_mem_resp,
    output i_mem_rdata
  );

endinterface

// File: rtl/if_id_fetch_ctrl_skid.sv
// One-entry {pc, ir} skid buffer that catches an instruction returned while
// the pipeline is frozen. Clear and unload both empty it; clear wins over load.
module if_skid_buf
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  fetch_entry_t data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
    end else if (clear || unload) begin
      full <= 1'b0;
    end else if (load) begin
      data <= din;
      full <= 1'b1;
    end
  end

  assign dout = data;

endmodule

// File: rtl/if_id_fetch_ctrl.sv
// LC-3b fetch controller and IF/ID register: owns the PC, drives the I-mem
// handshake, handles stall/skid and branch redirect. IF_PERF_CNT_EN adds counters.
module if_id_fetch_ctrl
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  if_id_fetch_ctrl_if.master        imem,
  input  logic                      dcache_stall,
  input  logic                      br_taken,
  input  lc3b_word                  br_target,
  output lc3b_word                  if_id_pc,
  output lc3b_word                  if_id_ir,
  output logic                      if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output lc3b_word                  perf_fetch_wait,
  output lc3b_word                  perf_flush
`endif
);

  fetch_state_t state;
  fetch_state_t state_next;
  lc3b_word     pc;
  lc3b_word     pc_next;
  lc3b_word     stale_addr;
  lc3b_word     stale_addr_next;
  lc3b_word     if_id_pc_next;
  lc3b_word     if_id_ir_next;
  logic         if_id_valid_next;

  logic         mem_read;
  logic         br_q;
  logic         skid_load;
  logic         skid_unload;
  logic         skid_clear;
  logic         skid_full;
  fetch_entry_t skid_in;
  fetch_entry_t skid_out;

  // A branch seen during a stall is held by downstream, so only act once unstalled.
  assign br_q    = br_taken && !dcache_stall;
  assign skid_in = '{pc: pc, ir: imem.i_mem_rdata};

  if_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    (skid_in),
    .dout   (skid_out),
    .full   (skid_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      stale_addr  <= RESET_PC;
      if_id_pc    <= '0;
      if_id_ir    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      stale_addr  <= stale_addr_next;
      if_id_pc    <= if_id_pc_next;
      if_id_ir    <= if_id_ir_next;
      if_id_valid <= if_id_valid_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    stale_addr_next  = stale_addr;
    if_id_pc_next    = if_id_pc;
    if_id_ir_next    = if_id_ir;
    if_id_valid_next = if_id_valid;
    skid_load        = 1'b0;
    skid_unload      = 1'b0;
    skid_clear       = 1'b0;
    mem_read         = rst_n && (state != HOLD);

    if (br_q) begin
      pc_next          = br_target;
      if_id_valid_next = 1'b0;
      skid_clear       = 1'b0 | 1'b1;
      // An unanswered read must be drained at its original address before redirecting.
      if (mem_read && !imem.i_mem_resp) begin
        state_next = DRAIN;
        if (state == FETCH) begin
          stale_addr_next = pc;
        end
      end else begin
        state_next = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem.i_mem_resp) begin
            pc_next = pc + PC_INC;
            if (!dcache_stall) begin
              if_id_pc_next    = pc;
              if_id_ir_next    = imem.i_mem_rdata;
              if_id_valid_next = 1'b1;
            end else begin
              skid_load  = 1'b1;
              state_next = HOLD;
            end
          end else if (!dcache_stall) begin
            if_id_valid_next = 1'b0;
          end
        end
        DRAIN: begin
          if (imem.i_mem_resp) begin
            state_next = FETCH;
          end
          if (!dcache_stall) begin
            if_id_valid_next = 1'b0;
          end
        end
        HOLD: begin
          if (!dcache_stall) begin
            if_id_pc_next    = skid_out.pc;
            if_id_ir_next    = skid_out.ir;
            if_id_valid_next = skid_full;
            skid_unload      = 1'b1;
            state_next       = FETCH;
          end
        end
        default: begin
          state_next = FETCH;
        end
      endcase
    end
  end

  assign imem.i_mem_read    = mem_read;
  assign imem.i_mem_address = (state == DRAIN) ? stale_addr : pc;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_wait <= '0;
      perf_flush      <= '0;
    end else begin
      if (mem_read && !imem.i_mem_resp) begin
        perf_fetch_wait <= sat_inc(perf_fetch_wait);
      end
      if (br_q) begin
        perf_flush <= sat_inc(perf_flush);
      end
    end
  end
`endif

endmodule
